// File: rtl/udatapath_param_if.sv
// Bus bundle between the ARC control unit / memory interface and the datapath.
// The master side is the controller (drives MIR fields, ALU code, memory data);
// the slave side is the datapath itself.
interface udatapath_param_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDR_WIDTH    = 6
);
  // Control inputs to the datapath
  logic [3:0]               uDataPath_ALUSelection_In;
  logic [ADDR_WIDTH-1:0]    uDataPath_MirRegisterA;
  logic [ADDR_WIDTH-1:0]    uDataPath_MirRegisterB;
  logic [ADDR_WIDTH-1:0]    uDataPath_MirRegisterC;
  logic                     uDataPath_A_Select_MUX_MIR;
  logic                     uDataPath_B_Select_MUX_MIR;
  logic                     uDataPath_C_Select_MUX_MIR;
  logic                     uDataPath_Write_Enable;
  logic [DATAWIDTH_BUS-1:0] uDataPath_MemData_In;
  logic                     uDataPath_MemData_Select;

  // Datapath outputs
  logic [DATAWIDTH_BUS-1:0] uDataPath_A_Bus;
  logic [DATAWIDTH_BUS-1:0] uDataPath_B_Bus;
  logic [DATAWIDTH_BUS-1:0] uDataPath_C_Bus;
  logic [7:0]               uDataPath_op;
  logic                     uDataPath_IR13;
  logic                     uDataPath_Negative_InLow;
  logic                     uDataPath_Zero_InLow;
  logic                     uDataPath_Overflow_InLow;
  logic                     uDataPath_Carry_InLow;
  logic                     UU_uDataPath_Set_Codes_Out;

  modport master (
    output uDataPath_ALUSelection_In,
    output uDataPath_MirRegisterA,
    output uDataPath_MirRegisterB,
    output uDataPath_MirRegisterC,
    output uDataPath_A_Select_MUX_MIR,
    output uDataPath_B_Select_MUX_MIR,
    output uDataPath_C_Select_MUX_MIR,
    output uDataPath_Write_Enable,
    output uDataPath_MemData_In,
    output uDataPath_MemData_Select,
    input  uDataPath_A_Bus,
    input  uDataPath_B_Bus,
    input  uDataPath_C_Bus,
    input  uDataPath_op,
    input  uDataPath_IR13,
    input  uDataPath_Negative_InLow,
    input  uDataPath_Zero_InLow,
    input  uDataPath_Overflow_InLow,
    input  uDataPath_Carry_InLow,
    input  UU_uDataPath_Set_Codes_Out
  );

  modport slave (
    input  uDataPath_ALUSelection_In,
    input  uDataPath_MirRegisterA,
    input  uDataPath_MirRegisterB,
    input  uDataPath_MirRegisterC,
    input  uDataPath_A_Select_MUX_MIR,
    input  uDataPath_B_Select_MUX_MIR,
    input  uDataPath_C_Select_MUX_MIR,
    input  uDataPath_Write_Enable,
    input  uDataPath_MemData_In,
    input  uDataPath_MemData_Select,
    output uDataPath_A_Bus,
    output uDataPath_B_Bus,
    output uDataPath_C_Bus,
    output uDataPath_op,
    output uDataPath_IR13,
    output uDataPath_Negative_InLow,
    output uDataPath_Zero_InLow,
    output uDataPath_Overflow_InLow,
    output uDataPath_Carry_InLow,
    output UU_uDataPath_Set_Codes_Out
  );
endinterface

// File: rtl/udatapath_param.sv
// ARC micro-programmed datapath: register bank (r0-r31, PC, temp0-3, IR),
// MIR/IR address selection, 16-function ALU and PSR flag register.
// Register reads are combinational, writes and flag updates are clocked.
module udatapath_param #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int REG_COUNT     = 38,
  parameter int ADDR_WIDTH    = 6
) (
  input logic                uDataPath_CLOCK_50,
  input logic                uDATAPATH_RESET_InHigh,
  udatapath_param_if.slave   dpBus
);

  localparam int W = DATAWIDTH_BUS;

  // ALU function codes
  localparam logic [3:0] ALU_ANDCC    = 4'd0;
  localparam logic [3:0] ALU_ORCC     = 4'd1;
  localparam logic [3:0] ALU_NORCC    = 4'd2;
  localparam logic [3:0] ALU_ADDCC    = 4'd3;
  localparam logic [3:0] ALU_SRL      = 4'd4;
  localparam logic [3:0] ALU_AND      = 4'd5;
  localparam logic [3:0] ALU_OR       = 4'd6;
  localparam logic [3:0] ALU_NOR      = 4'd7;
  localparam logic [3:0] ALU_ADD      = 4'd8;
  localparam logic [3:0] ALU_LSHIFT2  = 4'd9;
  localparam logic [3:0] ALU_LSHIFT10 = 4'd10;
  localparam logic [3:0] ALU_SIMM13   = 4'd11;
  localparam logic [3:0] ALU_SEXT13   = 4'd12;
  localparam logic [3:0] ALU_INC      = 4'd13;
  localparam logic [3:0] ALU_INCPC    = 4'd14;
  localparam logic [3:0] ALU_RSHIFT5  = 4'd15;

  // PSR bit positions
  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  // r0 is hard-wired to zero, so it has no storage; IR lives at the top slot.
  logic [W-1:0] regFile [1:REG_COUNT-1];
  logic [3:0]   psrReg;
  logic [3:0]   psrNext;

  logic [W-1:0] irReg;
  logic [31:0]  irWide;
  logic [7:0]   unusedIrBits;

  logic [ADDR_WIDTH-1:0] aAddr;
  logic [ADDR_WIDTH-1:0] bAddr;
  logic [ADDR_WIDTH-1:0] cAddr;

  logic [W-1:0] aBus;
  logic [W-1:0] bBus;
  logic [W-1:0] cBus;
  logic [W-1:0] aluResult;
  logic [W:0]   addWide;
  logic         setCodes;

  // The IR always occupies the last architectural register. Its fields are
  // defined on a 32-bit instruction word, so narrower buses zero-extend here.
  assign irReg        = regFile[REG_COUNT-1];
  assign irWide       = 32'(irReg);
  assign unusedIrBits = irWide[12:5];

  // Register address selection: MIR field, or the rs1/rs2/rd field of the IR
  assign aAddr = dpBus.uDataPath_A_Select_MUX_MIR ? dpBus.uDataPath_MirRegisterA
                                                  : ADDR_WIDTH'(irWide[18:14]);
  assign bAddr = dpBus.uDataPath_B_Select_MUX_MIR ? dpBus.uDataPath_MirRegisterB
                                                  : ADDR_WIDTH'(irWide[4:0]);
  assign cAddr = dpBus.uDataPath_C_Select_MUX_MIR ? dpBus.uDataPath_MirRegisterC
                                                  : ADDR_WIDTH'(irWide[29:25]);

  // Combinational read ports; r0 and addresses past the bank fall through to 0
  always_comb begin
    aBus = '0;
    bBus = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (aAddr == ADDR_WIDTH'(i)) aBus = regFile[i];
      if (bAddr == ADDR_WIDTH'(i)) bBus = regFile[i];
    end
  end

  // ALU: one shared adder for ADD/ADDCC, everything else is pure logic
  always_comb begin
    addWide   = {1'b0, aBus} + {1'b0, bBus};
    aluResult = '0;
    case (dpBus.uDataPath_ALUSelection_In)
      ALU_ANDCC,
      ALU_AND:      aluResult = aBus & bBus;
      ALU_ORCC,
      ALU_OR:       aluResult = aBus | bBus;
      ALU_NORCC,
      ALU_NOR:      aluResult = ~(aBus | bBus);
      ALU_ADDCC,
      ALU_ADD:      aluResult = addWide[W-1:0];
      ALU_SRL:      aluResult = aBus >> bBus[4:0];
      ALU_LSHIFT2:  aluResult = aBus << 2;
      ALU_LSHIFT10: aluResult = aBus << 10;
      ALU_SIMM13:   aluResult = {{(W-13){1'b0}}, aBus[12:0]};
      ALU_SEXT13:   aluResult = {{(W-13){aBus[12]}}, aBus[12:0]};
      ALU_INC:      aluResult = aBus + W'(1);
      ALU_INCPC:    aluResult = aBus + W'(4);
      ALU_RSHIFT5:  aluResult = W'($signed(aBus) >>> 5);
      default:      aluResult = '0;
    endcase
  end

  // Only the four CC ops (codes 0-3) touch the PSR
  assign setCodes = (dpBus.uDataPath_ALUSelection_In[3:2] == 2'b00);

  // Next PSR value: hold unless a CC op is selected; logic CC ops clear V and C
  always_comb begin
    psrNext = psrReg;
    if (setCodes) begin
      psrNext[PSR_N] = aluResult[W-1];
      psrNext[PSR_Z] = (aluResult == '0);
      psrNext[PSR_V] = 1'b0;
      psrNext[PSR_C] = 1'b0;
      if (dpBus.uDataPath_ALUSelection_In == ALU_ADDCC) begin
        psrNext[PSR_C] = addWide[W];
        psrNext[PSR_V] = (aBus[W-1] == bBus[W-1]) && (aluResult[W-1] != aBus[W-1]);
      end
    end
  end

  // Write-back source: memory read data or the ALU result
  assign cBus = dpBus.uDataPath_MemData_Select ? dpBus.uDataPath_MemData_In : aluResult;

  // Register bank write; reset takes priority over a same-cycle write
  always_ff @(posedge uDataPath_CLOCK_50) begin
    if (uDATAPATH_RESET_InHigh) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regFile[i] <= '0;
      end
    end else if (dpBus.uDataPath_Write_Enable) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (cAddr == ADDR_WIDTH'(i)) regFile[i] <= cBus;
      end
    end
  end

  // PSR register, updated independently of Write_Enable
  always_ff @(posedge uDataPath_CLOCK_50) begin
    if (uDATAPATH_RESET_InHigh) begin
      psrReg <= 4'b0000;
    end else begin
      psrReg <= psrNext;
    end
  end

  // Outputs: buses, opcode fields for the control store, active-low flags
  assign dpBus.uDataPath_A_Bus            = aBus;
  assign dpBus.uDataPath_B_Bus            = bBus;
  assign dpBus.uDataPath_C_Bus            = cBus;
  assign dpBus.uDataPath_op               = {irWide[31:30], irWide[24:19]};
  assign dpBus.uDataPath_IR13             = irWide[13];
  assign dpBus.uDataPath_Negative_InLow   = ~psrReg[PSR_N];
  assign dpBus.uDataPath_Zero_InLow       = ~psrReg[PSR_Z];
  assign dpBus.uDataPath_Overflow_InLow   = ~psrReg[PSR_V];
  assign dpBus.uDataPath_Carry_InLow      = ~psrReg[PSR_C];
  assign dpBus.UU_uDataPath_Set_Codes_Out = setCodes;

endmodule

// File: tb/tb_udatapath_param.sv
// Directed self-checking bench for udatapath_param.
module tb_udatapath_param;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  udatapath_param_if #(.DATAWIDTH_BUS(32), .ADDR_WIDTH(6)) dpIf ();

  udatapath_param #(.DATAWIDTH_BUS(32), .REG_COUNT(38), .ADDR_WIDTH(6)) dut (
    .uDataPath_CLOCK_50     (clk),
    .uDATAPATH_RESET_InHigh (rst),
    .dpBus                  (dpIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Idle: non-CC ALU code, MIR addressing, no writes
  task automatic idleInputs();
    dpIf.uDataPath_ALUSelection_In  = 4'd8;
    dpIf.uDataPath_MirRegisterA     = '0;
    dpIf.uDataPath_MirRegisterB     = '0;
    dpIf.uDataPath_MirRegisterC     = '0;
    dpIf.uDataPath_A_Select_MUX_MIR = 1'b1;
    dpIf.uDataPath_B_Select_MUX_MIR = 1'b1;
    dpIf.uDataPath_C_Select_MUX_MIR = 1'b1;
    dpIf.uDataPath_Write_Enable     = 1'b0;
    dpIf.uDataPath_MemData_In       = '0;
    dpIf.uDataPath_MemData_Select   = 1'b0;
  endtask

  // Load a register from the memory data path
  task automatic memWrite(input logic [5:0] addr, input logic [31:0] data);
    @(negedge clk);
    dpIf.uDataPath_ALUSelection_In  = 4'd8;
    dpIf.uDataPath_C_Select_MUX_MIR = 1'b1;
    dpIf.uDataPath_MirRegisterC     = addr;
    dpIf.uDataPath_MemData_Select   = 1'b1;
    dpIf.uDataPath_MemData_In       = data;
    dpIf.uDataPath_Write_Enable     = 1'b1;
    @(posedge clk);
    #1;
    dpIf.uDataPath_Write_Enable     = 1'b0;
    dpIf.uDataPath_MemData_Select   = 1'b0;
    $display("memWrite addr=%0d data=%h", addr, data);
  endtask

  // Read a register through the A bus
  task automatic readReg(input logic [5:0] addr, output logic [31:0] val);
    dpIf.uDataPath_A_Select_MUX_MIR = 1'b1;
    dpIf.uDataPath_MirRegisterA     = addr;
    #1;
    val = dpIf.uDataPath_A_Bus;
  endtask

  // One ALU cycle with MIR addressing; returns the pre-edge C bus and Set_Codes
  task automatic aluOp(input logic [3:0] code, input logic [5:0] a, input logic [5:0] b,
                       input logic [5:0] c, input logic we,
                       output logic [31:0] res, output logic sc);
    @(negedge clk);
    dpIf.uDataPath_ALUSelection_In  = code;
    dpIf.uDataPath_A_Select_MUX_MIR = 1'b1;
    dpIf.uDataPath_B_Select_MUX_MIR = 1'b1;
    dpIf.uDataPath_C_Select_MUX_MIR = 1'b1;
    dpIf.uDataPath_MirRegisterA     = a;
    dpIf.uDataPath_MirRegisterB     = b;
    dpIf.uDataPath_MirRegisterC     = c;
    dpIf.uDataPath_MemData_Select   = 1'b0;
    dpIf.uDataPath_Write_Enable     = we;
    #1;
    res = dpIf.uDataPath_C_Bus;
    sc  = dpIf.UU_uDataPath_Set_Codes_Out;
    @(posedge clk);
    #1;
    dpIf.uDataPath_Write_Enable     = 1'b0;
    dpIf.uDataPath_ALUSelection_In  = 4'd8;
    $display("aluOp code=%0d a=r%0d b=r%0d c=r%0d we=%0b result=%h", code, a, b, c, we, res);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] res;
    logic        sc;
    memWrite(6'd5, 32'h0000AAAA);
    memWrite(6'd37, 32'hFFFFFFFF);
    aluOp(4'd1, 6'd37, 6'd37, 6'd0, 1'b0, res, sc);
    checks++;
    if (dpIf.uDataPath_Negative_InLow !== 1'b0) begin
      errors++; $display("FAIL pre_reset_N: got %b expected 0", dpIf.uDataPath_Negative_InLow);
    end
    // Reset with a competing write to r5: reset must win
    @(negedge clk);
    rst = 1'b1;
    dpIf.uDataPath_MirRegisterC   = 6'd5;
    dpIf.uDataPath_MemData_Select = 1'b1;
    dpIf.uDataPath_MemData_In     = 32'h00005555;
    dpIf.uDataPath_Write_Enable   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleInputs();
    $display("reset applied with competing write to r5");
    readReg(6'd5, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_r5: got %h expected 00000000", v); end
    readReg(6'd37, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected 00000000", v); end
    checks++;
    if (dpIf.uDataPath_op !== 8'h00 || dpIf.uDataPath_IR13 !== 1'b0) begin
      errors++; $display("FAIL reset_op: got op=%h ir13=%b expected op=00 ir13=0",
                         dpIf.uDataPath_op, dpIf.uDataPath_IR13);
    end
    checks++;
    if ({dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow} !== 4'b1111) begin
      errors++; $display("FAIL reset_flags: got %b%b%b%b expected 1111",
                         dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
                         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow);
    end
  endtask

  task automatic test_addcc_overflow();
    logic [31:0] v;
    logic [31:0] res;
    logic        sc;
    memWrite(6'd1, 32'h7FFFFFFF);
    memWrite(6'd2, 32'h00000001);
    aluOp(4'd3, 6'd1, 6'd2, 6'd3, 1'b1, res, sc);
    checks++;
    if (res !== 32'h80000000 || sc !== 1'b1) begin
      errors++; $display("FAIL addcc_ovf_cbus: got %h sc=%b expected 80000000 sc=1", res, sc);
    end
    readReg(6'd3, v);
    checks++;
    if (v !== 32'h80000000) begin errors++; $display("FAIL addcc_ovf_r3: got %h expected 80000000", v); end
    checks++;
    if ({dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow} !== 4'b0101) begin
      errors++; $display("FAIL addcc_ovf_flags: got NZVC_n=%b%b%b%b expected 0101",
                         dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
                         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow);
    end
  endtask

  task automatic test_carry_zero();
    logic [31:0] v;
    logic [31:0] res;
    logic        sc;
    memWrite(6'd1, 32'hFFFFFFFF);
    memWrite(6'd2, 32'h00000001);
    aluOp(4'd3, 6'd1, 6'd2, 6'd3, 1'b1, res, sc);
    checks++;
    if (res !== 32'h0) begin errors++; $display("FAIL carry_zero_cbus: got %h expected 00000000", res); end
    checks++;
    if ({dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow} !== 4'b1010) begin
      errors++; $display("FAIL carry_zero_flags: got NZVC_n=%b%b%b%b expected 1010",
                         dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
                         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow);
    end
    // Plain ADD must leave the flags alone
    aluOp(4'd8, 6'd1, 6'd2, 6'd4, 1'b1, res, sc);
    checks++;
    if (sc !== 1'b0) begin errors++; $display("FAIL add_setcodes: got %b expected 0", sc); end
    checks++;
    if ({dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow} !== 4'b1010) begin
      errors++; $display("FAIL add_flags_hold: got NZVC_n=%b%b%b%b expected 1010",
                         dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
                         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow);
    end
    readReg(6'd4, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL add_r4: got %h expected 00000000", v); end
    // ANDCC without a register write: N set, V and C cleared
    aluOp(4'd0, 6'd1, 6'd1, 6'd6, 1'b0, res, sc);
    checks++;
    if ({dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow} !== 4'b0111) begin
      errors++; $display("FAIL andcc_flags: got NZVC_n=%b%b%b%b expected 0111",
                         dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
                         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow);
    end
    readReg(6'd6, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL andcc_no_write: got %h expected 00000000", v); end
  endtask

  task automatic test_ir_mux();
    logic [31:0] v;
    memWrite(6'd1, 32'h11111111);
    memWrite(6'd4, 32'h44444444);
    memWrite(6'd37, 32'h8A006004);
    @(negedge clk);
    dpIf.uDataPath_A_Select_MUX_MIR = 1'b0;
    dpIf.uDataPath_B_Select_MUX_MIR = 1'b0;
    dpIf.uDataPath_C_Select_MUX_MIR = 1'b0;
    dpIf.uDataPath_MirRegisterA     = 6'd2;
    dpIf.uDataPath_MirRegisterB     = 6'd2;
    dpIf.uDataPath_MirRegisterC     = 6'd2;
    dpIf.uDataPath_ALUSelection_In  = 4'd8;
    dpIf.uDataPath_Write_Enable     = 1'b1;
    #1;
    checks++;
    if (dpIf.uDataPath_A_Bus !== 32'h11111111 || dpIf.uDataPath_B_Bus !== 32'h44444444) begin
      errors++; $display("FAIL ir_mux_ab: got A=%h B=%h expected A=11111111 B=44444444",
                         dpIf.uDataPath_A_Bus, dpIf.uDataPath_B_Bus);
    end
    checks++;
    if (dpIf.uDataPath_op !== 8'h80 || dpIf.uDataPath_IR13 !== 1'b1) begin
      errors++; $display("FAIL ir_op: got op=%h ir13=%b expected op=80 ir13=1",
                         dpIf.uDataPath_op, dpIf.uDataPath_IR13);
    end
    @(posedge clk);
    #1;
    idleInputs();
    $display("ir-addressed ADD rd=r5");
    readReg(6'd5, v);
    checks++;
    if (v !== 32'h55555555) begin errors++; $display("FAIL ir_rd_r5: got %h expected 55555555", v); end
    readReg(6'd2, v);
    checks++;
    if (v !== 32'h00000001) begin errors++; $display("FAIL ir_mir_c_ignored: got %h expected 00000001", v); end
  endtask

  task automatic test_r0_range();
    logic [31:0] v;
    memWrite(6'd0, 32'h00001234);
    memWrite(6'd40, 32'h00001234);
    readReg(6'd0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL r0_write: got %h expected 00000000", v); end
    readReg(6'd40, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL addr40_write: got %h expected 00000000", v); end
    readReg(6'd1, v);
    checks++;
    if (v !== 32'h11111111) begin errors++; $display("FAIL range_r1: got %h expected 11111111", v); end
    readReg(6'd5, v);
    checks++;
    if (v !== 32'h55555555) begin errors++; $display("FAIL range_r5: got %h expected 55555555", v); end
    readReg(6'd37, v);
    checks++;
    if (v !== 32'h8A006004) begin errors++; $display("FAIL range_ir: got %h expected 8a006004", v); end
    // Read-during-write of r7: old value before the edge, new value after
    memWrite(6'd7, 32'hAAAA0000);
    @(negedge clk);
    dpIf.uDataPath_MirRegisterA     = 6'd7;
    dpIf.uDataPath_MirRegisterC     = 6'd7;
    dpIf.uDataPath_MemData_Select   = 1'b1;
    dpIf.uDataPath_MemData_In       = 32'h00000777;
    dpIf.uDataPath_Write_Enable     = 1'b1;
    #1;
    checks++;
    if (dpIf.uDataPath_A_Bus !== 32'hAAAA0000) begin
      errors++; $display("FAIL rdw_old: got %h expected aaaa0000", dpIf.uDataPath_A_Bus);
    end
    @(posedge clk);
    #1;
    idleInputs();
    $display("read-during-write r7");
    readReg(6'd7, v);
    checks++;
    if (v !== 32'h00000777) begin errors++; $display("FAIL rdw_new: got %h expected 00000777", v); end
  endtask

  task automatic test_shift_ext();
    logic [31:0] res;
    logic        sc;
    memWrite(6'd1, 32'h00001FFF);
    aluOp(4'd12, 6'd1, 6'd0, 6'd0, 1'b0, res, sc);
    checks++;
    if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL sext13: got %h expected ffffffff", res); end
    aluOp(4'd11, 6'd1, 6'd0, 6'd0, 1'b0, res, sc);
    checks++;
    if (res !== 32'h00001FFF) begin errors++; $display("FAIL simm13: got %h expected 00001fff", res); end
    memWrite(6'd1, 32'h80000000);
    memWrite(6'd2, 32'h00000004);
    aluOp(4'd15, 6'd1, 6'd0, 6'd0, 1'b0, res, sc);
    checks++;
    if (res !== 32'hFC000000) begin errors++; $display("FAIL rshift5: got %h expected fc000000", res); end
    aluOp(4'd4, 6'd1, 6'd2, 6'd0, 1'b0, res, sc);
    checks++;
    if (res !== 32'h08000000) begin errors++; $display("FAIL srl4: got %h expected 08000000", res); end
    aluOp(4'd14, 6'd1, 6'd0, 6'd0, 1'b0, res, sc);
    checks++;
    if (res !== 32'h80000004) begin errors++; $display("FAIL incpc: got %h expected 80000004", res); end
    checks++;
    if ({dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow} !== 4'b0111) begin
      errors++; $display("FAIL shift_flags_hold: got NZVC_n=%b%b%b%b expected 0111",
                         dpIf.uDataPath_Negative_InLow, dpIf.uDataPath_Zero_InLow,
                         dpIf.uDataPath_Overflow_InLow, dpIf.uDataPath_Carry_InLow);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_addcc_overflow();
    test_carry_zero();
    test_ir_mux();
    test_r0_range();
    test_shift_ext();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udatapath_param.md
Name: udatapath_param

Overview:
Parametrised micro-programmed datapath for the ARC processor core. It contains the register bank (general registers, PC, temporaries and IR), the A/B/C register-address selection between MIR fields and IR fields, the 16-function ALU, and a clocked PSR flag register. It sits between the control unit (MIR, ALU select) and the memory interface (A/B buses out, read data in), and feeds opcode fields and flags back to the control store.

Parameters:
DATAWIDTH_BUS, 32, data/register width W (at least 16).
REG_COUNT, 38, number of architectural registers.
ADDR_WIDTH, 6, register-address width. Must satisfy 2^ADDR_WIDTH >= REG_COUNT.

Ports:
uDataPath_CLOCK_50  in  1  system clock; all state updates on the rising edge.
uDATAPATH_RESET_InHigh  in  1  synchronous reset, active-high.
uDataPath_ALUSelection_In  in  4  ALU function code.
uDataPath_MirRegisterA/B/C  in  ADDR_WIDTH each  register addresses from the MIR.
uDataPath_A/B/C_Select_MUX_MIR  in  1 each  1 = use the MIR address; 0 = use the IR field.
uDataPath_Write_Enable  in  1  write the C bus into the register addressed by C.
uDataPath_MemData_In  in  W  memory read data.
uDataPath_MemData_Select  in  1  C-bus source: 1 = MemData_In, 0 = ALU result.
uDataPath_A_Bus / uDataPath_B_Bus  out  W  register-read buses (memory address and write data).
uDataPath_C_Bus  out  W  write-back bus.
uDataPath_op  out  8  {IR[31:30], IR[24:19]}.
uDataPath_IR13  out  1  IR[13].
uDataPath_Negative/Zero/Overflow/Carry_InLow  out  1 each  PSR flags, active-low (output = ~PSR bit).
UU_uDataPath_Set_Codes_Out  out  1  high while the current ALU code is a CC-setting op.

Behaviour:
- Register map:
  - 0-31: general registers; r0 always reads 0 and ignores writes.
  - 32: PC. 33-36: temp0-temp3. 37 (REG_COUNT-1): IR.
  - Addresses >= REG_COUNT read 0 and ignore writes.
- IR fields, zero-extended to ADDR_WIDTH:
  - A selects rs1 = IR[18:14].
  - B selects rs2 = IR[4:0].
  - C selects rd = IR[29:25].
- Reads are combinational. Write occurs on the clock edge when Write_Enable=1. A read of the register being written in the same cycle returns the old value; there is no bypass.
- ALU codes (A, B operands):
  - 0 ANDCC, 1 ORCC, 2 NORCC, 3 ADDCC
  - 4 SRL (A >> B[4:0], logical)
  - 5 AND, 6 OR, 7 NOR, 8 ADD
  - 9 LSHIFT2 (A << 2), 10 LSHIFT10 (A << 10)
  - 11 SIMM13 (A[12:0] zero-extended), 12 SEXT13 (A[12:0] sign-extended)
  - 13 INC (A + 1), 14 INCPC (A + 4), 15 RSHIFT5 (A >> 5, sign-preserving)
- Set_Codes_Out = 1 for codes 0-3. On a clock edge where Set_Codes_Out=1, the PSR latches:
  - N = result[W-1]; Z = (result == 0).
  - ADDCC: C = carry out of bit W-1; V = (A[W-1] == B[W-1]) && (result[W-1] != A[W-1]).
  - ANDCC/ORCC/NORCC: V = 0, C = 0.
- PSR updates are independent of Write_Enable; flags may update with no register write. For all other codes the PSR holds its value.
- Arithmetic wraps modulo 2^W. Non-CC ops never alter flags.
- Reset (synchronous, wins over any write in the same cycle):
  - All registers cleared to 0, PSR = 0000.
  - Flag outputs therefore read 1 (inactive).
  - A/B/C buses reflect r0 / IR = 0, so uDataPath_op = 0 and IR13 = 0.
- Latency: register write and flag update become visible 1 cycle after the edge; bus outputs are combinational from the current state.

Test Plan:
1. Reset: assert reset 1 cycle with Write_Enable=1, C=5 -> all registers 0, flag outputs all 1, op = 0.
2. ADDCC overflow: r1 = 0x7FFFFFFF, r2 = 1, code 3, C = 3 -> r3 = 0x80000000, N=1, V=1, C=0, Z=0 (outputs N_InLow=0, V_InLow=0).
3. Carry/zero: r1 = 0xFFFFFFFF, r2 = 1, ADDCC -> result 0, Z=1, C=1, V=0. Next, ADD with the same operands -> flags unchanged.
4. IR field muxing: load IR = 0x8A00_6004 via MemData_Select, all selects = 0 -> A reads r1, B reads r4, writes go to r5; op = {2'b10, 6'b000000}, IR13 = 1.
5. r0 and out-of-range addresses: write 0x1234 to address 0 and to address 40 -> both read 0 and no other register changes. Read-during-write of r7 returns the old value, then the new value next cycle.
6. Shifts and extension: A = 0x00001FFF -> SEXT13 gives 0xFFFFFFFF, SIMM13 gives 0x00001FFF. A = 0x80000000 -> RSHIFT5 gives 0xFC000000, SRL by 4 gives 0x08000000.
